// File: rtl/flow_pkg.sv
// Shared definitions for the decode-stage flow decoder: opcodes, flow classes,
// decode flags and the branch-history counter reset value.
package flow_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        FC_NONE,
        FC_J,
        FC_JAL,
        FC_JR,
        FC_BEQ,
        FC_BNE
    } flow_class_e;

    typedef struct packed {
        logic isJmp;
        logic isJr;
        logic isBr;
        logic isLink;
    } flow_flags_t;

    function automatic flow_class_e classify(input logic [5:0] op, input logic [5:0] fn);
        flow_class_e cls;
        cls = FC_NONE;
        unique case (op)
            OP_J:     cls = FC_J;
            OP_JAL:   cls = FC_JAL;
            OP_BEQ:   cls = FC_BEQ;
            OP_BNE:   cls = FC_BNE;
            OP_RTYPE: cls = (fn == FN_JR) ? FC_JR : FC_NONE;
            default:  cls = FC_NONE;
        endcase
        return cls;
    endfunction

    // Weakly-not-taken: one below the taken threshold.
    function automatic int unsigned ctrResetVal(input int unsigned ctrBits);
        return (32'd1 << (ctrBits - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/flow_bht.sv
// Branch history table: saturating counters with a combinational read port and
// a synchronous update port. Only built when FLOW_DEC_BHT_EN is defined.
`ifdef FLOW_DEC_BHT_EN
module flow_bht
    import flow_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CTR_BITS = 2,
    localparam int unsigned IDXW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] rdIdx,
    output logic            rdTakenC,
    input  logic            updValid,
    input  logic [IDXW-1:0] updIdx,
    input  logic            updTaken
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctrResetVal(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] ctr [DEPTH];

    // Read returns the pre-update value when read and update share an index.
    assign rdTakenC = ctr[rdIdx][CTR_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (updValid) begin
            if (updTaken) begin
                if (ctr[updIdx] != CTR_MAX) begin
                    ctr[updIdx] <= ctr[updIdx] + CTR_BITS'(1);
                end
            end else if (ctr[updIdx] != '0) begin
                ctr[updIdx] <= ctr[updIdx] - CTR_BITS'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/flow_decoder.sv
// Registered flow-control decoder (j/jal/jr/beq/bne) with target computation
// and branch prediction; FLOW_DEC_BHT_EN selects the BHT over static backward-taken.
module flow_decoder
    import flow_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CTR_BITS  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [31:0]      cmdIn,
    input  logic [WIDTH-1:0] pcIn,
    input  logic             stall,
    input  logic             flush,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    output logic             valid_out,
    output logic             isJmp,
    output logic             isJr,
    output logic             isBr,
    output logic             isLink,
    output logic             predTaken,
    output logic             redirect,
    output logic [WIDTH-1:0] target,
    output logic [31:0]      cmdOut
);

    localparam int unsigned SEXT_W = WIDTH - 18;

    flow_class_e      clsC;
    flow_flags_t      flagsC;
    logic [WIDTH-1:0] pcp4C;
    logic [WIDTH-1:0] jTgtC;
    logic [WIDTH-1:0] brTgtC;
    logic [WIDTH-1:0] tgtC;
    logic             predRawC;
    logic             predC;
    logic             redirectC;

    assign clsC   = classify(cmdIn[31:26], cmdIn[5:0]);
    assign pcp4C  = pcIn + WIDTH'(4);
    assign brTgtC = pcp4C + {{SEXT_W{cmdIn[15]}}, cmdIn[15:0], 2'b00};

    // At WIDTH=28 the pseudo-direct target has no region bits from pc+4.
    generate
        if (WIDTH == 28) begin : gJTgt28
            assign jTgtC = {cmdIn[25:0], 2'b00};
        end else begin : gJTgt
            assign jTgtC = {pcp4C[WIDTH-1:28], cmdIn[25:0], 2'b00};
        end
    endgenerate

`ifdef FLOW_DEC_BHT_EN
    localparam int unsigned IDXW = $clog2(BHT_DEPTH);

    logic unusedUpdPc;
    assign unusedUpdPc = ^{upd_pc[WIDTH-1:IDXW+2], upd_pc[1:0]};

    flow_bht #(
        .DEPTH    (BHT_DEPTH),
        .CTR_BITS (CTR_BITS)
    ) uBht (
        .clk      (clk),
        .reset    (reset),
        .rdIdx    (pcIn[IDXW+1:2]),
        .rdTakenC (predRawC),
        .updValid (upd_valid),
        .updIdx   (upd_pc[IDXW+1:2]),
        .updTaken (upd_taken)
    );
`else
    logic unusedCfg;
    assign unusedCfg = ^{upd_valid, upd_pc, upd_taken, 32'(BHT_DEPTH), 32'(CTR_BITS)};

    // Static backward-taken: a negative offset predicts taken.
    assign predRawC = cmdIn[15];
`endif

    // Decode flags and the per-class target.
    always_comb begin
        flagsC = '0;
        tgtC   = '0;
        unique case (clsC)
            FC_J: begin
                flagsC.isJmp = 1'b1;
                tgtC         = jTgtC;
            end
            FC_JAL: begin
                flagsC.isJmp  = 1'b1;
                flagsC.isLink = 1'b1;
                tgtC          = jTgtC;
            end
            FC_JR: begin
                flagsC.isJmp = 1'b1;
                flagsC.isJr  = 1'b1;
            end
            FC_BEQ, FC_BNE: begin
                flagsC.isBr = 1'b1;
                tgtC        = brTgtC;
            end
            default: begin
                flagsC = '0;
            end
        endcase
    end

    assign predC     = flagsC.isBr & predRawC;
    assign redirectC = (clsC == FC_J) | (clsC == FC_JAL) | predC;

    // Output register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            isJmp     <= 1'b0;
            isJr      <= 1'b0;
            isBr      <= 1'b0;
            isLink    <= 1'b0;
            predTaken <= 1'b0;
            redirect  <= 1'b0;
            target    <= '0;
            cmdOut    <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
            isJmp     <= 1'b0;
            isJr      <= 1'b0;
            isBr      <= 1'b0;
            isLink    <= 1'b0;
            predTaken <= 1'b0;
            redirect  <= 1'b0;
        end else if (!stall) begin
            valid_out <= valid_in;
            isJmp     <= valid_in & flagsC.isJmp;
            isJr      <= valid_in & flagsC.isJr;
            isBr      <= valid_in & flagsC.isBr;
            isLink    <= valid_in & flagsC.isLink;
            predTaken <= valid_in & predC;
            redirect  <= valid_in & redirectC;
            target    <= valid_in ? tgtC : '0;
            cmdOut    <= cmdIn;
        end
    end

endmodule
